// File: rtl/mac_seq_ctrl.sv
// Initiator-side sequencer for one single-cycle MAC slice: takes dot-product jobs,
// streams operand pairs into the MAC, then reads back the accumulated result.
module mac_seq_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic             job_mode,
    input  logic [LEN_W-1:0] job_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_error,
    output logic             busy,
    output logic             mac_cfg,
    output logic             mac_mode,
    output logic             mac_enable,
    output logic             mac_valid,
    output logic             mac_read,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    input  logic [15:0]      mac_result,
    input  logic             mac_error
);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        ACC,
        READ,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             err_q, err_d;
    logic             first_q, first_d;
    logic [15:0]      res_data_q, res_data_d;
    logic             res_error_q, res_error_d;

    logic job_ready_q, job_ready_d;
    logic busy_q, busy_d;
    logic op_ready_q, op_ready_d;
    logic cfg_q, cfg_d;
    logic enable_q, enable_d;
    logic read_q, read_d;
    logic res_valid_q, res_valid_d;

    // The MAC commits the previous beat's product on each beat after the first,
    // so that is when its error flag means something for this job.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remain_d    = remain_q;
        err_d       = err_q;
        first_d     = first_q;
        res_data_d  = res_data_q;
        res_error_d = res_error_q;

        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    mode_d   = job_mode;
                    remain_d = job_len;
                    err_d    = 1'b0;
                    state_d  = CFG;
                end
            end
            CFG: begin
                first_d = 1'b1;
                state_d = (remain_q != '0) ? ACC : READ;
            end
            ACC: begin
                if (op_valid) begin
                    remain_d = remain_q - LEN_W'(1);
                    first_d  = 1'b0;
                    if (!first_q) begin
                        err_d = err_q | mac_error;
                    end
                    if (remain_q == LEN_W'(1)) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                res_data_d  = mac_result;
                res_error_d = err_q | mac_error;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        job_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        op_ready_d  = (state_d == ACC);
        cfg_d       = (state_d == CFG);
        enable_d    = (state_d == ACC) || (state_d == READ);
        read_d      = (state_d == READ);
        res_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            remain_q    <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            res_data_q  <= 16'h0000;
            res_error_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            cfg_q       <= 1'b0;
            enable_q    <= 1'b0;
            read_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remain_q    <= remain_d;
            err_q       <= err_d;
            first_q     <= first_d;
            res_data_q  <= res_data_d;
            res_error_q <= res_error_d;
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
            cfg_q       <= cfg_d;
            enable_q    <= enable_d;
            read_q      <= read_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Operands pass straight through during ACC; idle beats present zeros.
    assign mac_valid  = op_ready_q & op_valid;
    assign mac_a      = mac_valid ? op_a : 16'h0000;
    assign mac_b      = mac_valid ? op_b : 16'h0000;

    assign job_ready  = job_ready_q;
    assign busy       = busy_q;
    assign op_ready   = op_ready_q;
    assign mac_cfg    = cfg_q;
    assign mac_enable = enable_q;
    assign mac_read   = read_q;
    assign mac_mode   = mode_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_error  = res_error_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl; a behavioural MAC slice stands in for mac_top.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_ready, job_mode;
    logic [7:0]  job_len;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic        res_valid, res_ready, res_error, busy;
    logic [15:0] res_data;
    logic        mac_cfg, mac_mode, mac_enable, mac_valid, mac_read;
    logic [15:0] mac_a, mac_b, mac_result;
    logic        mac_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] va [0:7];
    logic [15:0] vb [0:7];

    mac_seq_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode), .job_len(job_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_error(res_error),
        .busy(busy),
        .mac_cfg(mac_cfg), .mac_mode(mac_mode), .mac_enable(mac_enable), .mac_valid(mac_valid),
        .mac_read(mac_read), .mac_a(mac_a), .mac_b(mac_b),
        .mac_result(mac_result), .mac_error(mac_error)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(int'(h[9:0])) / 1024.0;
        for (int i = 15; i < e; i++) m = m * 2.0;
        for (int i = e; i < 15; i++) m = m / 2.0;
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2f(input real r);
        logic s;
        int   e;
        int   mant;
        real  x;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        x = s ? -r : r;
        e = 15;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0) begin x = x * 2.0; e--; end
        mant = $rtoi((x - 1.0) * 1024.0 + 0.5);
        return {s, 5'(e), 10'(mant)};
    endfunction

    // MAC model: a beat registers a*b, the next beat commits the held product,
    // read returns acc+product combinationally. An overflowing commit is dropped.
    logic m_mode = 1'b0;
    logic m_pv   = 1'b0;
    logic m_ovf;
    real  m_acc  = 0.0;
    real  m_prod = 0.0;
    real  m_sum, m_newprod;

    always_comb begin
        m_sum      = m_acc + (m_pv ? m_prod : 0.0);
        m_ovf      = m_mode ? (m_sum > 65504.0 || m_sum < -65504.0)
                            : (m_sum > 32767.0 || m_sum < -32768.0);
        mac_error  = m_pv && m_ovf && mac_enable && (mac_valid || mac_read);
        mac_result = 16'h0000;
        if (!m_ovf) mac_result = m_mode ? r2f(m_sum) : 16'($rtoi(m_sum));
        m_newprod  = m_mode ? f2r(mac_a) * f2r(mac_b)
                            : real'(int'($signed(mac_a[7:0]))) * real'(int'($signed(mac_b[7:0])));
    end

    always @(posedge clk) begin
        if (rst || mac_cfg || (mac_enable && mac_read)) begin
            m_pv   <= 1'b0;
            m_acc  <= 0.0;
            m_prod <= 0.0;
            if (rst) m_mode <= 1'b0;
            else if (mac_cfg) m_mode <= mac_mode;
        end else if (mac_enable && mac_valid) begin
            if (m_pv) m_acc <= m_ovf ? 0.0 : m_sum;
            m_prod <= m_newprod;
            m_pv   <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // Runs one job up to the first res_valid cycle; lat counts cycles from the
    // handshake edge, -1 if the result never arrives.
    task automatic do_job(input logic mode, input logic [7:0] len, input int stall_at,
                          input int stall_n, output int lat, output int cfg_cnt,
                          output logic cfg_mode, output logic stall_ok, output logic proto_ok);
        int beat;
        int stall_left;
        beat = 0; stall_left = stall_n; lat = -1; cfg_cnt = 0;
        cfg_mode = 1'b0; stall_ok = 1'b1; proto_ok = 1'b1;
        job_valid = 1'b1; job_mode = mode; job_len = len;
        tick();
        job_valid = 1'b0; job_mode = 1'b0; job_len = 8'd0;
        for (int t = 0; t < 300; t++) begin
            if (mac_cfg) begin cfg_cnt++; cfg_mode = mac_mode; end
            if (res_valid) begin lat = t + 1; break; end
            if (op_ready && beat < int'(len)) begin
                if (beat == stall_at && stall_left > 0) begin
                    op_valid = 1'b0;
                    stall_left--;
                    #1;
                    if (!(mac_enable && !mac_valid)) stall_ok = 1'b0;
                end else begin
                    op_valid = 1'b1; op_a = va[beat]; op_b = vb[beat];
                    beat++;
                end
            end else begin
                op_valid = 1'b0;
            end
            #1;
            if ((mac_cfg && mac_enable) || (mac_read && mac_valid)) proto_ok = 1'b0;
            tick();
        end
        op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (job_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_job_ready: got %b want 1", job_ready); end
        n_cmp++; if ({busy, res_valid, res_error, op_ready} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_status: got %b want 0000", {busy, res_valid, res_error, op_ready}); end
        n_cmp++; if (res_data !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_res_data: got %h want 0000", res_data); end
        n_cmp++; if ({mac_cfg, mac_mode, mac_enable, mac_valid, mac_read} !== 5'b00000) begin n_err++; $display("[TB] FAIL reset_mac_ctl: got %b want 00000", {mac_cfg, mac_mode, mac_enable, mac_valid, mac_read}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_int8();
        int lat, cc; logic cm, so, po;
        va[0] = 16'h0002; vb[0] = 16'h0003;
        va[1] = 16'h0004; vb[1] = 16'h0005;
        va[2] = 16'hFFFF; vb[2] = 16'h0007;
        do_job(1'b0, 8'd3, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h0013) begin n_err++; $display("[TB] FAIL int8_data: got %h want 0013", res_data); end
        n_cmp++; if (res_error !== 1'b0) begin n_err++; $display("[TB] FAIL int8_error: got %b want 0", res_error); end
        n_cmp++; if (lat !== 6) begin n_err++; $display("[TB] FAIL int8_latency: got %0d want 6", lat); end
        n_cmp++; if (cc !== 1 || cm !== 1'b0) begin n_err++; $display("[TB] FAIL int8_cfg: got count %0d mode %b want count 1 mode 0", cc, cm); end
        n_cmp++; if (po !== 1'b1) begin n_err++; $display("[TB] FAIL int8_protocol_overlap: got %b want 1", po); end
        accept();
    endtask

    task automatic test_fp16();
        int lat, cc; logic cm, so, po;
        va[0] = 16'h3C00; vb[0] = 16'h4000;
        va[1] = 16'h3C00; vb[1] = 16'h3C00;
        do_job(1'b1, 8'd2, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h4200) begin n_err++; $display("[TB] FAIL fp16_data: got %h want 4200", res_data); end
        n_cmp++; if (cm !== 1'b1) begin n_err++; $display("[TB] FAIL fp16_cfg_mode: got %b want 1", cm); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL fp16_latency: got %0d want 5", lat); end
        accept();
    endtask

    task automatic test_stall();
        int lat, cc; logic cm, so, po;
        va[0] = 16'h0002; vb[0] = 16'h0003;
        va[1] = 16'h0004; vb[1] = 16'h0005;
        va[2] = 16'hFFFF; vb[2] = 16'h0007;
        do_job(1'b0, 8'd3, 1, 4, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h0013) begin n_err++; $display("[TB] FAIL stall_data: got %h want 0013", res_data); end
        n_cmp++; if (lat !== 10) begin n_err++; $display("[TB] FAIL stall_latency: got %0d want 10", lat); end
        n_cmp++; if (so !== 1'b1) begin n_err++; $display("[TB] FAIL stall_enable_hold: got %b want 1", so); end
        accept();
    endtask

    task automatic test_sticky_error();
        int lat, cc; logic cm, so, po;
        va[0] = 16'h7BFF; vb[0] = 16'h7BFF;
        va[1] = 16'h3C00; vb[1] = 16'h3C00;
        do_job(1'b1, 8'd2, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_error !== 1'b1) begin n_err++; $display("[TB] FAIL sticky_error: got %b want 1", res_error); end
        n_cmp++; if (res_data !== 16'h3C00) begin n_err++; $display("[TB] FAIL sticky_data: got %h want 3c00", res_data); end
        accept();
    endtask

    task automatic test_zero_len();
        int lat, cc; logic cm, so, po;
        do_job(1'b0, 8'd0, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (lat !== 3) begin n_err++; $display("[TB] FAIL zero_latency: got %0d want 3", lat); end
        n_cmp++; if (res_data !== 16'h0000 || res_error !== 1'b0) begin n_err++; $display("[TB] FAIL zero_result: got %h/%b want 0000/0", res_data, res_error); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 16'h0000 || job_ready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL zero_backpressure: got valid %b data %h job_ready %b want 1 0000 0", res_valid, res_data, job_ready);
            end
        end
        accept();
        n_cmp++; if (res_valid !== 1'b0 || job_ready !== 1'b1) begin n_err++; $display("[TB] FAIL zero_accept: got valid %b job_ready %b want 0 1", res_valid, job_ready); end
    endtask

    task automatic test_back_to_back();
        int lat, cc; logic cm, so, po;
        va[0] = 16'h0005; vb[0] = 16'h0006;
        do_job(1'b0, 8'd1, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h001E) begin n_err++; $display("[TB] FAIL b2b_first: got %h want 001e", res_data); end
        accept();
        va[0] = 16'hFFFE; vb[0] = 16'hFFFD;
        va[1] = 16'h0064; vb[1] = 16'h0064;
        do_job(1'b0, 8'd2, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h2716) begin n_err++; $display("[TB] FAIL b2b_second: got %h want 2716", res_data); end
        n_cmp++; if (lat !== 5) begin n_err++; $display("[TB] FAIL b2b_latency: got %0d want 5", lat); end
        accept();
    endtask

    task automatic test_reset_mid_job();
        int lat, cc; logic cm, so, po;
        job_valid = 1'b1; job_mode = 1'b0; job_len = 8'd5;
        tick();
        job_valid = 1'b0; job_len = 8'd0;
        tick();
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1; op_a = 16'h0007; op_b = 16'h0007;
            tick();
        end
        op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
        n_cmp++; if (busy !== 1'b1 || op_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midjob_in_acc: got busy %b op_ready %b want 1 1", busy, op_ready); end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({busy, res_valid, res_error, op_ready, mac_cfg, mac_mode, mac_enable, mac_valid, mac_read} !== 9'b0
                || res_data !== 16'h0000 || mac_a !== 16'h0000 || job_ready !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL midjob_reset_outputs: got flags %b data %h job_ready %b want all 0, job_ready 1",
                         {busy, res_valid, res_error, op_ready, mac_cfg, mac_mode, mac_enable, mac_valid, mac_read}, res_data, job_ready);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("[TB] FAIL midjob_stale_result: got %b want 0", res_valid); end
        va[0] = 16'h0003; vb[0] = 16'h0003;
        do_job(1'b0, 8'd1, -1, 0, lat, cc, cm, so, po);
        n_cmp++; if (res_data !== 16'h0009 || res_error !== 1'b0) begin n_err++; $display("[TB] FAIL midjob_new_job: got %h/%b want 0009/0", res_data, res_error); end
        n_cmp++; if (lat !== 4) begin n_err++; $display("[TB] FAIL midjob_latency: got %0d want 4", lat); end
        accept();
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_mode = 1'b0; job_len = 8'd0;
        op_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000; res_ready = 1'b0;
        test_reset();
        test_int8();
        test_fp16();
        test_stall();
        test_sticky_error();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Initiator-side sequencer for the single-cycle MAC slice (`mac_top`). It accepts dot-product jobs on a ready/valid job port and streams operand pairs from an operand port. It drives the MAC's cfg/enable/valid/read protocol and returns the accumulated result and error flag on a ready/valid result port. It sits between the operand buffer or DMA and one MAC slice. The system top ties the MAC's `rst_n` to `~rst`.

## Interface
- `LEN_W`, default 8: width of the job length field; maximum pairs per job is 2^LEN_W-1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `job_valid` in 1: job request.
- `job_ready` out 1: high only in IDLE.
- `job_mode` in 1: 1 = fp16, 0 = int8.
- `job_len` in LEN_W: number of operand pairs; 0 is legal.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: high only in ACC.
- `op_a`, `op_b` in 16: operand pair.
- `res_valid` out 1: result valid; held until `res_ready`.
- `res_ready` in 1: result accept.
- `res_data` out 16: accumulated result.
- `res_error` out 1: sticky MAC error for the job.
- `busy` out 1: high in any state other than IDLE.
- `mac_cfg`, `mac_mode`, `mac_enable`, `mac_valid`, `mac_read` out 1: MAC control signals.
- `mac_a`, `mac_b` out 16: MAC operands.
- `mac_result` in 16: combinational MAC output.
- `mac_error` in 1: combinational MAC error.

## Operation
- FSM states: IDLE, CFG, ACC, READ, RESP.
- **IDLE**
  - On `job_valid`: latch `job_mode` into `mode_q` and `job_len` into `remain`, clear `err_q`, go to CFG.
- **CFG** (exactly one cycle)
  - Drives `mac_cfg`=1, `mac_enable`=0, `mac_mode`=`mode_q`.
  - Next state: ACC if `remain`≠0, else READ.
- **ACC**
  - Drives `mac_enable`=1, `op_ready`=1, `mac_valid`=`op_valid`.
  - `mac_a`/`mac_b` = `op_a`/`op_b` when `op_valid`, else 0.
  - On each beat (`op_valid`): `remain`-1. On the beat where `remain`==1, go to READ.
  - `op_valid` low: enable stays high and valid stays low, so the MAC holds its state. Stalls of any length are legal.
- **READ** (exactly one cycle)
  - Drives `mac_enable`=1, `mac_read`=1, `mac_valid`=0.
  - Registers `mac_result` into `res_data`; the MAC clears its internal registers on this edge.
  - Registers `err_q | mac_error` into `res_error`. Go to RESP.
- **RESP**
  - `res_valid`=1; `res_data` and `res_error` stable.
  - On `res_ready`: go to IDLE.
- **Error capture:** `err_q` ORs in `mac_error` on every ACC beat after the first, because that is when the MAC commits its previous product to the accumulator.
- **Defaults:** in any state, outputs not listed above are 0. `mac_mode` holds `mode_q` in all states.
- **Arithmetic:** none in this block. Width and overflow behaviour belong to the MAC; `res_data` is `mac_result` bit-exact.
- **`job_len`=0:** CFG then READ; `res_data`=0 (MAC registers already cleared), `res_error`=0.
- **Reset:**
  - Any state -> IDLE; `remain`, `err_q`, `mode_q` = 0.
  - All outputs 0 at reset: `res_data`=0, `res_error`=0, `res_valid`=0, `busy`=0.
  - Exception: `job_ready` is 1 in the first cycle after reset.
  - A reset mid-job discards the job with no result; the MAC is reset by the same edge.

## Timing
- Job handshake in cycle T -> CFG at T+1.
- ACC starts at T+2. With `op_valid` held high, N beats occupy T+2..T+1+N.
- READ at T+2+N; `res_valid` rises at T+3+N.
- Total latency to result is N+3 cycles, plus one cycle per operand stall.
- Next job is accepted no earlier than the cycle after `res_ready`, so two jobs are separated by at least one IDLE cycle.
- `mac_cfg` never coincides with `mac_enable`. `mac_read` never coincides with `mac_valid`.
- The MAC's read output is valid only in READ; `mac_result` is ignored in all other states.

## Test plan
- **int8 job**
  - Stimulus: int8, `job_len`=3, pairs (2,3), (4,5), (-1,7) back-to-back.
  - Expected: `res_data`=19 (0x0013), `res_error`=0; `res_valid` 6 cycles after the job handshake; `mac_cfg` asserted once with `mac_mode`=0.
- **fp16 job**
  - Stimulus: fp16, `job_len`=2, pairs (0x3C00,0x4000), (0x3C00,0x3C00).
  - Expected: `res_data`=0x4200, `mac_mode`=1 during CFG.
- **Operand stalls**
  - Stimulus: the int8 job above with `op_valid` low for 4 cycles between beats 1 and 2.
  - Expected: same result 19; latency +4; `mac_enable` stays high with `mac_valid` low during the stall.
- **Zero length and backpressure**
  - Stimulus: `job_len`=0, then `res_ready` held low for 5 cycles.
  - Expected: `res_data`=0; `res_valid` held with stable data; `job_ready` low until the accept.
- **Sticky error**
  - Stimulus: fp16 job where an intermediate accumulation overflows (pairs (0x7BFF,0x7BFF), (0x3C00,0x3C00)).
  - Expected: `res_error`=1 even if the final `mac_error` is 0.
- **Reset mid-job**
  - Stimulus: assert `rst` during ACC after 2 of 5 beats, then a new job with `job_len`=1 and pair (3,3).
  - Expected: all outputs 0 while reset is asserted; no stale result; new job gives `res_data`=9.
